// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: two-flop synchronizer, counter-based
// debounce, registered press/release pulses and a per-channel auto-repeat FSM.
module button_conditioner #(
   parameter int N_BTN           = 5,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int REPEAT_DELAY    = 12500000,
   parameter int REPEAT_PERIOD   = 2500000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] btn_in,
   input  logic [N_BTN-1:0] repeat_en,
   output logic [N_BTN-1:0] press_pulse,
   output logic [N_BTN-1:0] release_pulse,
   output logic [N_BTN-1:0] level
);

   // One counter width serves both the debounce and the repeat timers.
   localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
   localparam int MAX_P = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
   localparam int CW    = $clog2(MAX_P) + 1;

   localparam logic [CW-1:0] CNT_MAX       = {CW{1'b1}};
   localparam logic [CW-1:0] DB_LAST       = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] DELAY_LAST    = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] PERIOD_LAST   = CW'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;

   logic [N_BTN-1:0] sync1_reg;
   logic [N_BTN-1:0] sync2_reg;

   // Bring the raw button levels into the clock domain before any decision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
      end else begin
         sync1_reg <= btn_in;
         sync2_reg <= sync1_reg;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_BTN; gi++) begin : g_chan
         logic [CW-1:0] db_cnt_reg;
         logic          level_reg;
         logic          release_reg;
         logic          press_reg;
         rpt_state_t    state_reg;
         logic [CW-1:0] rpt_cnt_reg;
         logic          differ;
         logic          toggle;
         logic          rise;
         logic          fall;

         // The level flips on the edge where the disagreement has lasted
         // DEBOUNCE_CYCLES cycles; rise/fall mark that edge for the pulses.
         assign differ = sync2_reg[gi] != level_reg;
         assign toggle = differ && (db_cnt_reg == DB_LAST);
         assign rise   = toggle && !level_reg;
         assign fall   = toggle && level_reg;

         // Debounce counter and accepted level; release pulse shares the edge.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               db_cnt_reg  <= '0;
               level_reg   <= 1'b0;
               release_reg <= 1'b0;
            end else begin
               release_reg <= fall;
               if (toggle) begin
                  level_reg  <= ~level_reg;
                  db_cnt_reg <= '0;
               end else if (differ) begin
                  if (db_cnt_reg != CNT_MAX)
                     db_cnt_reg <= db_cnt_reg + 1'b1;
               end else begin
                  db_cnt_reg <= '0;
               end
            end
         end

         // Auto-repeat FSM; a release always wins, so press and release never coincide.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               state_reg   <= IDLE;
               rpt_cnt_reg <= '0;
               press_reg   <= 1'b0;
            end else begin
               press_reg <= rise;
               if (fall) begin
                  state_reg   <= IDLE;
                  rpt_cnt_reg <= '0;
               end else begin
                  case (state_reg)
                     IDLE: begin
                        rpt_cnt_reg <= '0;
                        if (repeat_en[gi] && (level_reg || rise))
                           state_reg <= DELAY;
                     end
                     DELAY: begin
                        if (!repeat_en[gi]) begin
                           state_reg   <= IDLE;
                           rpt_cnt_reg <= '0;
                        end else if (rpt_cnt_reg == DELAY_LAST) begin
                           state_reg   <= REPEAT;
                           rpt_cnt_reg <= '0;
                           press_reg   <= 1'b1;
                        end else if (rpt_cnt_reg != CNT_MAX) begin
                           rpt_cnt_reg <= rpt_cnt_reg + 1'b1;
                        end
                     end
                     REPEAT: begin
                        if (!repeat_en[gi]) begin
                           state_reg   <= IDLE;
                           rpt_cnt_reg <= '0;
                        end else if (rpt_cnt_reg == PERIOD_LAST) begin
                           rpt_cnt_reg <= '0;
                           press_reg   <= 1'b1;
                        end else if (rpt_cnt_reg != CNT_MAX) begin
                           rpt_cnt_reg <= rpt_cnt_reg + 1'b1;
                        end
                     end
                     default: begin
                        state_reg   <= IDLE;
                        rpt_cnt_reg <= '0;
                     end
                  endcase
               end
            end
         end

         assign level[gi]         = level_reg;
         assign press_pulse[gi]   = press_reg;
         assign release_pulse[gi] = release_reg;
      end
   endgenerate

endmodule
